// File: rtl/cyp_fifo_bridge.sv
// FX2 slave-FIFO bridge: RX/TX word buffers plus a bus FSM that bursts reads
// from EP2, writes to EP6 and commits short packets with PKTEND.

module cyp_fifo_bridge_fifo #(
  parameter int DW = 16,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic [AW:0]   count
);
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW:0]   wp, rp;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= wdata;
  end

  // Show-ahead head; same index with differing MSBs means the pointers lapped.
  assign rdata = mem[rp[AW-1:0]];
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign count = wp - rp;
endmodule

module cyp_fifo_bridge #(
  parameter int         DATA_W    = 16,
  parameter int         RX_AW     = 9,
  parameter int         TX_AW     = 9,
  parameter logic [1:0] RX_EP     = 2'b00,
  parameter logic [1:0] TX_EP     = 2'b10,
  parameter int         BURST_MAX = 256
) (
  input  logic              cyp_clk,
  input  logic              rst,
  output logic              usb_clk,
  output logic [1:0]        usb_fifoaddr,
  output logic              usb_slcs,
  output logic              usb_sloe,
  output logic              usb_slrd,
  output logic              usb_slwr,
  output logic              usb_pktend,
  input  logic [DATA_W-1:0] usb_fd_i,
  output logic [DATA_W-1:0] usb_fd_o,
  output logic              usb_fd_oe,
  input  logic              usb_flaga,
  input  logic              usb_flagc,
  input  logic              rx_ren,
  output logic [DATA_W-1:0] rx_rdata,
  output logic              rx_empty,
  output logic [RX_AW:0]    rx_count,
  input  logic              tx_wen,
  input  logic [DATA_W-1:0] tx_wdata,
  output logic              tx_full,
  input  logic              tx_flush,
  output logic              tx_ovf
);
  typedef enum logic [2:0] {IDLE, RD_PRE, RD, WR_PRE, WR, PKTEND, TURN} state_t;

  localparam logic [15:0] BMAX    = BURST_MAX[15:0];
  localparam logic [15:0] BMAX_M1 = BMAX - 16'd1;

  state_t state, nxt;
  logic [15:0] burst_cnt;
  logic last_wr, flush_pend;

  logic rx_full, rx_push, rx_pop;
  logic tx_empty, tx_push, tx_pop;
  logic [DATA_W-1:0] tx_head;
  logic [TX_AW:0] tx_count;

  logic rd_req, wr_req, pe_req, rd_go, wr_go;
  logic cnt_clr, grant_rd, grant_wr, pe_clr;

  cyp_fifo_bridge_fifo #(.DW(DATA_W), .AW(RX_AW)) u_rx_fifo (
    .clk(cyp_clk), .rst(rst), .push(rx_push), .wdata(usb_fd_i), .pop(rx_pop),
    .rdata(rx_rdata), .full(rx_full), .count(rx_count)
  );

  cyp_fifo_bridge_fifo #(.DW(DATA_W), .AW(TX_AW)) u_tx_fifo (
    .clk(cyp_clk), .rst(rst), .push(tx_push), .wdata(tx_wdata), .pop(tx_pop),
    .rdata(tx_head), .full(tx_full), .count(tx_count)
  );

  assign rx_empty = (rx_count == '0);
  assign tx_empty = (tx_count == '0);
  assign rx_pop   = rx_ren && !rx_empty;
  // A push into a full TX buffer still lands when the bus pops the head that cycle.
  assign tx_push  = tx_wen && (!tx_full || tx_pop);

  assign rd_req = usb_flaga && !rx_full;
  assign wr_req = usb_flagc && !tx_empty;
  assign pe_req = flush_pend && tx_empty && usb_flagc;
  assign rd_go  = usb_flaga && !rx_full && (burst_cnt < BMAX);
  assign wr_go  = usb_flagc && !tx_empty && (burst_cnt < BMAX);

  assign usb_clk  = cyp_clk;
  assign usb_slcs = 1'b0;
  assign usb_fd_o = usb_fd_oe ? tx_head : '1;

  always_ff @(posedge cyp_clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt          = state;
    usb_fifoaddr = RX_EP;
    usb_sloe     = 1'b1;
    usb_slrd     = 1'b1;
    usb_slwr     = 1'b1;
    usb_pktend   = 1'b1;
    usb_fd_oe    = 1'b0;
    rx_push      = 1'b0;
    tx_pop       = 1'b0;
    cnt_clr      = 1'b0;
    grant_rd     = 1'b0;
    grant_wr     = 1'b0;
    pe_clr       = 1'b0;
    case (state)
      IDLE: begin
        if (pe_req) nxt = PKTEND;
        else if (rd_req && (!wr_req || last_wr)) begin
          nxt      = RD_PRE;
          grant_rd = 1'b1;
        end else if (wr_req) begin
          nxt      = WR_PRE;
          grant_wr = 1'b1;
        end
      end
      RD_PRE: begin
        usb_sloe = 1'b0;
        cnt_clr  = 1'b1;
        nxt      = RD;
      end
      RD: begin
        usb_sloe = 1'b0;
        // Leaving on the last strobe keeps back-to-back bursts at a 3-cycle gap.
        if (rd_go) begin
          usb_slrd = 1'b0;
          rx_push  = 1'b1;
          if (burst_cnt == BMAX_M1) nxt = TURN;
        end else nxt = TURN;
      end
      WR_PRE: begin
        usb_fifoaddr = TX_EP;
        usb_fd_oe    = 1'b1;
        cnt_clr      = 1'b1;
        nxt          = WR;
      end
      WR: begin
        usb_fifoaddr = TX_EP;
        usb_fd_oe    = 1'b1;
        if (wr_go) begin
          usb_slwr = 1'b0;
          tx_pop   = 1'b1;
          if (burst_cnt == BMAX_M1) nxt = TURN;
        end else nxt = TURN;
      end
      PKTEND: begin
        usb_fifoaddr = TX_EP;
        usb_fd_oe    = 1'b1;
        usb_pktend   = 1'b0;
        pe_clr       = 1'b1;
        nxt          = TURN;
      end
      TURN:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge cyp_clk) begin
    if (rst) begin
      burst_cnt  <= '0;
      last_wr    <= 1'b1;
      flush_pend <= 1'b0;
      tx_ovf     <= 1'b0;
    end else begin
      if (cnt_clr)               burst_cnt <= '0;
      else if (rx_push || tx_pop) burst_cnt <= burst_cnt + 16'd1;
      if (grant_rd)      last_wr <= 1'b0;
      else if (grant_wr) last_wr <= 1'b1;
      if (pe_clr)        flush_pend <= 1'b0;
      else if (tx_flush) flush_pend <= 1'b1;
      if (tx_wen && tx_full && !tx_pop) tx_ovf <= 1'b1;
    end
  end
endmodule
